// File: rtl/imem_fetch_sequencer_pkg.sv
// Shared CPU constants: NOP encoding, sequencer state encoding and the
// opcode values decode also relies on.
package cpu_pkg;
   localparam logic [31:0] NOP_WORD = 32'b0;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [5:0] OP_ADDI = 6'b100000;
   localparam logic [5:0] OP_BEZ  = 6'b101000;
   localparam logic [5:0] OP_BNE  = 6'b101001;
   localparam logic [5:0] OP_JMP  = 6'b101010;
   localparam logic [5:0] OP_LD   = 6'b100100;
   localparam logic [5:0] OP_ST   = 6'b100101;
endpackage

// File: rtl/imem_fetch_sequencer_if.sv
// Loader stream and instruction-memory bus between the fetch sequencer
// (master) and the loader/imem side (slave).
interface imem_fetch_sequencer_if #(
   parameter int N  = 32,
   parameter int AW = 7
);
   logic          ld_valid;
   logic [N-1:0]  ld_data;
   logic          ld_last;
   logic          ld_ready;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [N-1:0]  imem_wdata;
   logic [N-1:0]  imem_raddr;
   logic [N-1:0]  imem_rdata;

   modport master (
      input  ld_valid, ld_data, ld_last, imem_rdata,
      output ld_ready, imem_we, imem_waddr, imem_wdata, imem_raddr
   );

   modport slave (
      output ld_valid, ld_data, ld_last, imem_rdata,
      input  ld_ready, imem_we, imem_waddr, imem_wdata, imem_raddr
   );
endinterface

// File: rtl/imem_fetch_sequencer_pc_reg.sv
// Program counter: synchronous clear, loads d when en is high, else holds.
module pc_reg #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst)     q <= '0;
      else if (en) q <= d;
   end
endmodule

// File: rtl/imem_fetch_sequencer.sv
// Instruction-memory sequencer: boot-loads imem from a word stream, then
// fetches into the IF/ID register with freeze, branch flush and reload.
module imem_fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   imem_fetch_sequencer_if.master bus,
   input  logic                  reload,
   input  logic                  freeze,
   input  logic                  branch_taken,
   input  logic [N-1:0]          branch_target,
   output logic [N-1:0]          if_instr,
   output logic [N-1:0]          if_pc,
   output logic                  if_valid,
   output logic                  running
);
   state_t        state_q, state_d;
   logic [AW-1:0] ld_ptr_q, ld_ptr_d;
   logic [N-1:0]  pc_q, pc_d;
   logic          pc_en;
   logic          ifid_en;
   logic [N-1:0]  ifi_d, ifpc_d;
   logic          ifv_d;
   logic [N-1:0]  pc_plus4;

   assign pc_plus4 = pc_q + N'(4);

   pc_reg #(.N(N)) u_pc (
      .clk (clk),
      .rst (rst),
      .en  (pc_en),
      .d   (pc_d),
      .q   (pc_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_LOAD;
         ld_ptr_q <= '0;
         if_instr <= NOP_WORD;
         if_pc    <= '0;
         if_valid <= 1'b0;
      end else begin
         state_q  <= state_d;
         ld_ptr_q <= ld_ptr_d;
         if (ifid_en) begin
            if_instr <= ifi_d;
            if_pc    <= ifpc_d;
            if_valid <= ifv_d;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ld_ptr_d     = ld_ptr_q;
      pc_d         = pc_q;
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifi_d        = NOP_WORD;
      ifpc_d       = '0;
      ifv_d        = 1'b0;
      bus.ld_ready = 1'b0;
      bus.imem_we  = 1'b0;
      case (state_q)
         ST_LOAD: begin
            // Not ready during the reset cycle so no word is half-accepted.
            bus.ld_ready = !rst;
            if (bus.ld_valid && !rst) begin
               bus.imem_we = 1'b1;
               ld_ptr_d    = ld_ptr_q + AW'(1);
               if (bus.ld_last || ld_ptr_q == AW'(DEPTH - 1)) begin
                  state_d  = ST_RUN;
                  ld_ptr_d = '0;
                  pc_d     = '0;
                  pc_en    = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (reload) begin
               state_d  = ST_LOAD;
               ld_ptr_d = '0;
               pc_d     = '0;
               pc_en    = 1'b1;
               ifid_en  = 1'b1;
            end else if (branch_taken) begin
               // Redirect wins over freeze: the branch is older than the stalled slot.
               pc_d    = {branch_target[N-1:2], 2'b00};
               pc_en   = 1'b1;
               ifid_en = 1'b1;
            end else if (!freeze) begin
               ifid_en = 1'b1;
               ifi_d   = bus.imem_rdata;
               ifpc_d  = pc_plus4;
               ifv_d   = 1'b1;
               pc_d    = pc_plus4;
               pc_en   = 1'b1;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   assign bus.imem_waddr = ld_ptr_q;
   assign bus.imem_wdata = bus.ld_data;
   assign bus.imem_raddr = pc_q;
   assign running        = (state_q == ST_RUN);
endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed + randomized bench for imem_fetch_sequencer against a
// cycle-level behavioural model of the load/run rules.
module tb_imem_fetch_sequencer;
   localparam int N = 32;
   localparam int DEPTH = 128;
   localparam int AW = 7;

   logic clk = 1'b0;
   logic rst, reload, freeze, branch_taken;
   logic [N-1:0] branch_target;
   logic [N-1:0] if_instr, if_pc;
   logic if_valid, running;

   imem_fetch_sequencer_if #(.N(N), .AW(AW)) bus ();

   imem_fetch_sequencer #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .reload        (reload),
      .freeze        (freeze),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .if_valid      (if_valid),
      .running       (running)
   );

   always #5 clk = ~clk;

   // imem behind the bus: combinational read, written on the DUT strobe
   logic [N-1:0] mem [DEPTH];
   assign bus.imem_rdata = mem[bus.imem_raddr[AW+1:2]];
   always @(posedge clk) if (bus.imem_we) mem[bus.imem_waddr] <= bus.imem_wdata;

   // reference model
   logic [N-1:0] m_mem [DEPTH];
   bit           m_load;
   int           m_ptr;
   logic [N-1:0] m_pc, m_instr, m_ifpc;
   bit           m_valid;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_load = 1; m_ptr = 0; m_pc = 0; m_instr = 0; m_ifpc = 0; m_valid = 0;
   endtask

   task automatic tick();
      bit exp_rdy, exp_we;
      #1;
      exp_rdy = !rst && m_load;
      exp_we  = exp_rdy && bus.ld_valid;
      check("ld_ready", N'(bus.ld_ready), N'(exp_rdy));
      check("imem_we", N'(bus.imem_we), N'(exp_we));
      if (exp_we) begin
         check("imem_waddr", N'(bus.imem_waddr), N'(m_ptr));
         check("imem_wdata", bus.imem_wdata, bus.ld_data);
      end
      check("imem_raddr", bus.imem_raddr, m_pc);
      @(posedge clk);
      if (rst) model_reset();
      else if (m_load) begin
         if (bus.ld_valid) begin
            m_mem[m_ptr] = bus.ld_data;
            if (bus.ld_last || m_ptr == DEPTH - 1) begin
               m_load = 0; m_ptr = 0; m_pc = 0;
            end else m_ptr++;
         end
      end else if (reload) begin
         m_load = 1; m_ptr = 0; m_pc = 0; m_instr = 0; m_ifpc = 0; m_valid = 0;
      end else if (branch_taken) begin
         m_pc = branch_target & ~32'd3; m_instr = 0; m_ifpc = 0; m_valid = 0;
      end else if (!freeze) begin
         m_instr = m_mem[(m_pc / 4) % DEPTH];
         m_ifpc  = m_pc + 4;
         m_valid = 1;
         m_pc    = m_pc + 4;
      end
      #1;
      check("if_instr", if_instr, m_instr);
      check("if_pc", if_pc, m_ifpc);
      check("if_valid", N'(if_valid), N'(m_valid));
      check("running", N'(running), N'(!m_load));
   endtask

   task automatic idle();
      rst = 0; reload = 0; freeze = 0; branch_taken = 0; branch_target = 0;
      bus.ld_valid = 0; bus.ld_data = 0; bus.ld_last = 0;
   endtask

   task automatic load_word(input logic [N-1:0] d, input bit last);
      bus.ld_valid = 1; bus.ld_data = d; bus.ld_last = last;
      tick();
      bus.ld_valid = 0; bus.ld_last = 0;
   endtask

   logic [N-1:0] w [5];
   logic [N-1:0] first_word;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin mem[i] = 0; m_mem[i] = 0; end
      model_reset();
      idle();
      rst = 1;
      tick();
      tick();
      check("rst_if_valid", N'(if_valid), 0);
      check("rst_running", N'(running), 0);
      rst = 0;

      // 1: three-word program, then in-order fetch
      load_word(32'hA1, 0);
      load_word(32'hB2, 0);
      load_word(32'hC3, 1);
      check("t1_running", N'(running), 1);
      tick(); check("t1_i0", if_instr, 32'hA1); check("t1_pc0", if_pc, 32'd4);
      tick(); check("t1_i1", if_instr, 32'hB2); check("t1_pc1", if_pc, 32'd8);
      tick(); check("t1_i2", if_instr, 32'hC3); check("t1_pc2", if_pc, 32'd12);
      tick();

      // 2: freeze at PC=0x10 for three cycles
      freeze = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_hold_pc", if_pc, 32'h10);
      end
      freeze = 0;
      tick(); check("t2_resume", if_pc, 32'h14);

      // 3: branch beats freeze, target alignment
      freeze = 1; branch_taken = 1; branch_target = 32'h2E;
      tick();
      check("t3_flush_instr", if_instr, 32'h0);
      check("t3_flush_valid", N'(if_valid), 0);
      freeze = 0; branch_taken = 0;
      tick(); check("t3_pc_after", if_pc, 32'h30);

      // 4: full-depth load ends by itself, then index wrap at 0x1FC
      reload = 1; tick(); reload = 0;
      first_word = $urandom;
      load_word(first_word, 0);
      for (int i = 1; i < DEPTH; i++) load_word($urandom, 0);
      check("t4_autorun", N'(running), 1);
      branch_taken = 1; branch_target = 32'h1FC; tick(); branch_taken = 0;
      tick(); check("t4_pc_200", if_pc, 32'h200);
      tick(); check("t4_wrap_instr", if_instr, first_word); check("t4_pc_204", if_pc, 32'h204);

      // 5: reset in the middle of a load, then reload five words
      reload = 1; tick(); reload = 0;
      for (int i = 0; i < 5; i++) w[i] = $urandom;
      load_word(w[0], 0); load_word(w[1], 0);
      rst = 1; bus.ld_valid = 1; bus.ld_data = w[2];
      tick();
      rst = 0; bus.ld_valid = 0;
      check("t5_rst_running", N'(running), 0);
      for (int i = 0; i < 5; i++) load_word(w[i], i == 4);
      for (int i = 0; i < 5; i++) check("t5_mem", mem[i], w[i]);

      // 6: reload with a loader word offered in the same cycle
      tick(); tick();
      reload = 1; bus.ld_valid = 1; bus.ld_data = 32'hDEAD0001;
      tick();
      reload = 0;
      check("t6_ready", N'(bus.ld_ready), 1);
      bus.ld_data = 32'hBEEF0002;
      tick();
      bus.ld_valid = 0;
      check("t6_mem0", mem[0], 32'hBEEF0002);

      // randomized mix of all controls
      for (int c = 0; c < 600; c++) begin
         rst           = ($urandom_range(99) == 0);
         reload        = ($urandom_range(39) == 0);
         freeze        = ($urandom_range(3) == 0);
         branch_taken  = ($urandom_range(5) == 0);
         branch_target = $urandom;
         bus.ld_valid  = $urandom_range(1);
         bus.ld_data   = $urandom;
         bus.ld_last   = ($urandom_range(9) == 0);
         tick();
      end
      idle();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
